// File: rtl/mc_datapath_regs.sv
// Sequential core of the multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut,
// their input muxes, the immediate extender, PC-next/branch logic and instret.
module mc_datapath_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcwrite,
    input  logic        memwrite,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        branch,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic        immExt,
    input  logic        branchBne,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic [31:0] instret
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMMW  = 16;
    localparam int unsigned JIMMW = 26;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] mdr_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] aluout_q;
    logic [XLEN-1:0] instret_q, instret_d;

    logic [XLEN-1:0] imm_ext_c;
    logic [XLEN-1:0] pc_next_c;
    logic [XLEN-1:0] jump_target_c;
    logic            pcen_c;

    // Zero-extend for logical immediates (ANDI/ORI), sign-extend otherwise.
    always_comb begin
        imm_ext_c = XLEN'({{IMMW{ir_q[IMMW-1]}}, ir_q[IMMW-1:0]});
        if (immExt) begin
            imm_ext_c = XLEN'({{IMMW{1'b0}}, ir_q[IMMW-1:0]});
        end
    end

    // ALU operand selection.
    always_comb begin
        alu_a = alusrca ? a_q : pc_q;
        alu_b = b_q;
        case (alusrcb)
            SRCB_REG:   alu_b = b_q;
            SRCB_FOUR:  alu_b = XLEN'(4);
            SRCB_IMM:   alu_b = imm_ext_c;
            SRCB_IMMSH: alu_b = {imm_ext_c[XLEN-3:0], 2'b00};
            default:    alu_b = b_q;
        endcase
    end

    // Jump target reuses the already-incremented PC's upper nibble.
    assign jump_target_c = {pc_q[XLEN-1:XLEN-4], ir_q[JIMMW-1:0], 2'b00};

    // PC-next selection and enable; BNE inverts the sense of the zero flag.
    always_comb begin
        pc_next_c = alu_result;
        case (pcsrc)
            PCSRC_ALU:    pc_next_c = alu_result;
            PCSRC_ALUOUT: pc_next_c = aluout_q;
            PCSRC_JUMP:   pc_next_c = jump_target_c;
            PCSRC_HOLD:   pc_next_c = pc_q;
            default:      pc_next_c = pc_q;
        endcase
        pcen_c = pcwrite | (branch & (alu_zero ^ branchBne));
    end

    // Next-state for the enabled registers.
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        if (pcen_c) begin
            pc_d = pc_next_c;
        end
        if (irwrite) begin
            ir_d      = mem_rdata;
            instret_d = instret_q + XLEN'(1);
        end
    end

    // MDR, A, B and ALUOut reload every cycle; PC, IR and instret are enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            aluout_q  <= '0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mem_rdata;
            a_q       <= rf_rd1;
            b_q       <= rf_rd2;
            aluout_q  <= alu_result;
            instret_q <= instret_d;
        end
    end

    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign rf_ra1    = ir_q[25:21];
    assign rf_ra2    = ir_q[20:16];
    assign rf_wa     = regdst ? ir_q[15:11] : ir_q[20:16];
    assign rf_wd     = memtoreg ? mdr_q : aluout_q;
    assign rf_we     = regwrite;
    assign mem_addr  = iord ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign mem_we    = memwrite;
    assign pc        = pc_q;
    assign instret   = instret_q;

endmodule

// File: doc/mc_datapath_regs.md
# mc_datapath_regs

Sequential core of the multicycle MIPS datapath, directly downstream of the main decoder FSM. It holds PC, IR, MDR, A, B and ALUOut. Per cycle, it applies the decoder's one-hot/encoded controls to these registers, the memory address mux, the ALU operand muxes, the immediate extender, the register-file write port and the PC-next/branch logic. It returns the opcode and funct fields to the decoder and keeps a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pcwrite, memwrite, irwrite, regwrite, alusrca, branch, iord, memtoreg, regdst, immExt, branchBne  in  1 each  decoder controls.
- alusrcb  in  2  ALU B select.
- pcsrc  in  2  PC-next select.
- op  out  6  IR[31:26], to the decoder.
- funct  out  6  IR[5:0], to the ALU decoder.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data, equal to B.
- mem_we  out  1  equal to memwrite.
- mem_rdata  in  32  memory read data, valid combinationally in the same cycle.
- rf_ra1, rf_ra2  out  5 each  IR[25:21] and IR[20:16].
- rf_rd1, rf_rd2  in  32 each  register-file read data.
- rf_we  out  1  equal to regwrite.
- rf_wa  out  5  write address.
- rf_wd  out  32  write data.
- alu_a, alu_b  out  32 each  ALU operands.
- alu_result  in  32  ALU result.
- alu_zero  in  1  ALU zero flag.
- pc  out  32  current PC.
- instret  out  32  count of retired fetches.

## Operation
Combinational paths:
- mem_addr = iord ? ALUOut : PC.
- alu_a = alusrca ? A : PC.
- alu_b is selected by alusrcb: 00 = B, 01 = 32'd4, 10 = ImmExt, 11 = ImmExt<<2 (low bits zero, upper bits discarded).
- ImmExt = immExt ? {16'h0, IR[15:0]} : {{16{IR[15]}}, IR[15:0]}.
- rf_wa = regdst ? IR[15:11] : IR[20:16].
- rf_wd = memtoreg ? MDR : ALUOut.
- PC-next is selected by pcsrc: 00 = alu_result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}, 11 = hold current PC.
- pcen = pcwrite | (branch & (alu_zero ^ branchBne)). With branchBne=0 the branch is taken on zero (BEQ); with branchBne=1 it is taken on non-zero (BNE).

Registers, all updated on the rising clk edge:
- PC <= PC-next when pcen; otherwise it holds.
- IR <= mem_rdata when irwrite; otherwise it holds.
- MDR <= mem_rdata every cycle.
- A <= rf_rd1, B <= rf_rd2 every cycle.
- ALUOut <= alu_result every cycle.
- instret increments by 1 on each cycle with irwrite=1. It wraps from 32'hFFFF_FFFF to 0.

Reset (asynchronous, dominates all enables):
- PC = RESET_PC.
- IR, MDR, A, B, ALUOut, instret = 0.
- Consequently op = 0, funct = 0, mem_addr = RESET_PC when iord=0, and mem_wdata = 0.

## Timing
- All register outputs change only at the rising clk edge or at reset assertion.
- mem_addr, alu_a, alu_b, rf_wa, rf_wd and mem_we/rf_we are combinational from registers and controls, with zero added latency.
- FETCH cycle (irwrite, pcwrite, alusrcb=01, pcsrc=00): IR captures M[PC] and PC becomes PC+4 at the same edge. op is valid in the following DECODE cycle.
- DECODE cycle: ALUOut captures PC+4+(SignImm<<2), the branch target.
- The branch cycle uses pcsrc=01 (ALUOut) and the zero flag from A−B in that same cycle. PC updates at the end of the branch cycle.
- Jump: PC gets the jump target at the end of the JEX cycle, using the already-incremented PC[31:28].
- A load (lw) needs MDR from the MEMRD cycle to be written in MEMWB. Because MDR reloads every cycle, it holds the MEMRD value for exactly one cycle.
- pcwrite together with a branch condition in the same cycle: pcen=1. PC-next is still selected only by pcsrc.
- If reset is released mid-instruction, execution restarts at RESET_PC. No partial IR, PC or instret state survives.

## Test plan
- Reset: assert reset mid-cycle with PC=32'h40 -> PC=0, instret=0, op=0 immediately, without waiting for a clock edge.
- Fetch: mem_rdata=32'h8C22_0004 (lw), FETCH controls -> after one edge: IR=32'h8C22_0004, op=6'b100011, PC=4, instret=1. Over MEMADR/MEMRD/MEMWB: mem_addr=ALUOut in MEMRD, rf_wd=MDR, rf_wa=2.
- BEQ: PC=8, offset=3, A=B (alu_zero=1), branch=1, branchBne=0, pcsrc=01 -> PC=8+12=20. Repeat with alu_zero=0 -> PC stays 8.
- BNE: same stimulus with branchBne=1 -> PC taken only when alu_zero=0.
- ANDI/ORI extension: IR[15:0]=16'h8001, immExt=1, alusrcb=10 -> alu_b=32'h0000_8001. With immExt=0 -> alu_b=32'hFFFF_8001. With alusrcb=11 and immExt=0 -> alu_b=32'hFFFE_0004.
- Jump and wrap: PC=32'hA000_0004, IR[25:0]=26'h100, pcsrc=10, pcwrite=1 -> PC=32'hA000_0400. Separately, preload instret=32'hFFFF_FFFF (force) and pulse irwrite -> instret=0.
